// File: rtl/debounce_bank.sv
// Debounces N asynchronous switch inputs; per channel: level, edge strobes, sticky flags.
// Latency: input change before edge k appears on state/strobe at edge k+1+STABLE_CYCLES.
// No backpressure: strobes are one-cycle pulses, sticky flags hold until clr_evt.
module debounce_bank #(
    parameter int   N             = 4,
    parameter int   STABLE_CYCLES = 1000000,
    parameter int   CNT_W         = 20,
    parameter logic INIT_STATE    = 1'b0
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [N-1:0] switch_input,
    input  logic [N-1:0] clr_evt,
    output logic [N-1:0] state,
    output logic [N-1:0] trans_up,
    output logic [N-1:0] trans_dn,
    output logic [N-1:0] up_seen,
    output logic [N-1:0] dn_seen,
    output logic         any_trans
);

    // Terminal count: the flip happens on the edge where the counter already holds this value.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);

    logic [N-1:0]            s1_q, s2_q;
    logic [N-1:0]            state_q, state_d;
    logic [N-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]            flip_up, flip_dn;
    logic [N-1:0]            trans_up_q, trans_dn_q;
    logic [N-1:0]            up_seen_q, up_seen_d;
    logic [N-1:0]            dn_seen_q, dn_seen_d;
    logic                    any_trans_q;

    // Per-channel stability counter: restarts on any return to the current level.
    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        flip_up = '0;
        flip_dn = '0;
        for (int i = 0; i < N; i++) begin
            if (s2_q[i] == state_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == LAST_CNT) begin
                cnt_d[i]   = '0;
                state_d[i] = s2_q[i];
                flip_up[i] = s2_q[i];
                flip_dn[i] = ~s2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Sticky flags: clear first, then a coincident set overrides it.
    always_comb begin
        up_seen_d = (up_seen_q & ~clr_evt) | flip_up;
        dn_seen_d = (dn_seen_q & ~clr_evt) | flip_dn;
    end

    // All state registers; reset returns every channel to INIT_STATE with no strobe.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_q        <= {N{INIT_STATE}};
            s2_q        <= {N{INIT_STATE}};
            state_q     <= {N{INIT_STATE}};
            cnt_q       <= '0;
            trans_up_q  <= '0;
            trans_dn_q  <= '0;
            up_seen_q   <= '0;
            dn_seen_q   <= '0;
            any_trans_q <= 1'b0;
        end else begin
            s1_q        <= switch_input;
            s2_q        <= s1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            trans_up_q  <= flip_up;
            trans_dn_q  <= flip_dn;
            up_seen_q   <= up_seen_d;
            dn_seen_q   <= dn_seen_d;
            any_trans_q <= |(flip_up | flip_dn);
        end
    end

    assign state     = state_q;
    assign trans_up  = trans_up_q;
    assign trans_dn  = trans_dn_q;
    assign up_seen   = up_seen_q;
    assign dn_seen   = dn_seen_q;
    assign any_trans = any_trans_q;

endmodule

// File: doc/debounce_bank.md
Name: debounce_bank

Overview:
- Parametrised, multi-channel successor to the single-switch debouncer.
- Debounces N asynchronous switch/button inputs in parallel.
- Per channel it provides the stable level, one-cycle rising/falling transition strobes, and sticky up/down event flags that software or an FSM clears.
- Sits between board pins and control logic such as LED drivers, mode selectors and the seven-segment multiplexer.

Parameters:
- N, 4, number of independent channels (1..32).
- STABLE_CYCLES, 1000000, consecutive CLK cycles a synchronised input must differ from the debounced state before the state flips (>=1).
- CNT_W, 20, per-channel counter width; must satisfy 2**CNT_W >= STABLE_CYCLES.
- INIT_STATE, 1'b0, reset level of every channel's synchroniser and debounced state.

Ports:
- CLK  input  1  system clock; all state changes on its rising edge.
- RST  input  1  asynchronous, active-high reset.
- switch_input  input  N  raw asynchronous switch levels, bit i = channel i.
- clr_evt  input  N  synchronous clear of the sticky flags for channel i.
- state  output  N  debounced level per channel.
- trans_up  output  N  one-cycle strobe when state[i] goes 0->1.
- trans_dn  output  N  one-cycle strobe when state[i] goes 1->0.
- up_seen  output  N  sticky flag: a rising transition occurred since the last clear.
- dn_seen  output  N  sticky flag: a falling transition occurred since the last clear.
- any_trans  output  1  OR of all trans_up and trans_dn bits, registered in the same cycle as the strobes.

Behaviour:
- Reset (RST=1, asynchronous, takes effect immediately):
  - Both synchroniser stages = INIT_STATE.
  - state = {N{INIT_STATE}}.
  - All counters = 0.
  - trans_up, trans_dn, up_seen, dn_seen, any_trans = 0.
  - No transition strobe is ever generated as a consequence of reset release.
- Synchroniser: two-flop chain per channel, s1 <= switch_input[i], s2 <= s1. Only s2 feeds the debouncer.
- Per-channel counter, evaluated every edge:
  - If s2 == state[i]: cnt <= 0.
  - Else if cnt == STABLE_CYCLES-1: state[i] <= s2, cnt <= 0, and the matching strobe (trans_up if s2=1, else trans_dn) = 1 for exactly that one cycle.
  - Else: cnt <= cnt+1.
  - The counter never wraps: it is bounded by STABLE_CYCLES-1 and returns to 0 on any glitch back to the current state.
- Latency: switch_input changes before edge k and then holds → state and the strobe update at edge k+1+STABLE_CYCLES. For STABLE_CYCLES=1 this is edge k+2.
- Bounce rejection: any return of s2 to state[i] before the count completes restarts the count from 0; no strobe is produced.
- Strobes: registered; deasserted on every cycle with no flip. trans_up[i] and trans_dn[i] are never both 1.
- Sticky flags:
  - up_seen[i] <= 1 on trans_up[i]; dn_seen[i] <= 1 on trans_dn[i].
  - Set and clr_evt[i] are evaluated on the same edge that registers the strobe. If a set and clr_evt[i] coincide on that edge, the set wins (flag = 1).
  - clr_evt[i] alone clears both flags of channel i on the next edge.
  - clr_evt has no effect on state, counters or strobes.
- Channel independence: simultaneous flips on several channels each strobe in the same cycle. any_trans = 1 if any channel flips.
- Reset mid-count: counters are lost, state returns to INIT_STATE, and there is no strobe. After release, an input held opposite to INIT_STATE produces a normal transition at release+2+STABLE_CYCLES edges.

Test Plan (N=4, STABLE_CYCLES=4, CNT_W=3, INIT_STATE=0):
1. Reset, hold switch_input=4'b0000 for 20 cycles → state=0, no strobes, any_trans=0. Release RST while switch_input=4'b0000 → no strobe.
2. Set switch_input[0]=1 before edge k and hold → state[0]=1 and trans_up[0]=1 at edge k+5 only; trans_up[0]=0 at k+6; up_seen[0]=1 from k+6 onward.
3. Bounce: switch_input[1] toggles 1,0,1,0 with each level held 3 cycles, then settles at 1 → no strobe during bouncing; one trans_up[1] at 5 edges after the final settle; dn_seen[1] stays 0.
4. Channels 2 and 3 rise on the same edge → trans_up[2] and trans_up[3] pulse in the same cycle; any_trans=1 for that single cycle.
5. Pulse clr_evt[0] on the exact edge channel 0 registers a falling strobe → dn_seen[0]=1 (set wins). A later clr_evt[0] with no transition → up_seen[0]=dn_seen[0]=0.
6. Assert RST 2 cycles into a 4-cycle count on channel 0 while its input is held opposite → outputs zero immediately. After release, trans_up[0] appears at the 6th edge after release, and nowhere earlier.
